// File: rtl/keycode_event_port_pkg.sv
// rtl/keycode_event_port_pkg.sv - register map and field positions for keycode_event_port
package keycode_evt_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_LIVE     = 2'd3;

    localparam int CNT_LSB   = 0;
    localparam int OVF_BIT   = 8;
    localparam int FULL_BIT  = 9;
    localparam int EMPTY_BIT = 10;
    localparam int VALID_BIT = 8;
    localparam int TS_W      = 16;

endpackage

// File: rtl/keycode_event_port_if.sv
// rtl/keycode_event_port_if.sv - Avalon-MM slave bus bundle for keycode_event_port
interface keycode_event_port_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/keycode_event_port_fifo.sv
// rtl/keycode_event_port_fifo.sv - keycode_evt_fifo: synchronous FIFO, pop ignored when empty,
// push accepted when full only if a pop happens in the same cycle
module keycode_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    assign rdata_o      = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/keycode_event_port.sv
// rtl/keycode_event_port.sv - synchronised keycode change-event queue on an Avalon-MM slave.
// KEYCODE_EVT_TIMESTAMP_EN adds a 16-bit timestamp per event, returned in DATA[31:16].
module keycode_event_port
    import keycode_evt_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int CAP_ON_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    keycode_event_port_if.slave  bus,
    input  logic [DATA_W-1:0]    in_port,
    output logic                 irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] s1_q, s2_q, prev_q;
    logic              ovf_q, ovf_d;
    logic              mask_q, mask_d;
    logic              irq_q, irq_d;
    logic              rd_strobe, wr_strobe, pop_req, push_req, ovf_set, ovf_clr;
    logic              full, empty;
    logic [CW-1:0]     count, count_next;
    logic [DATA_W-1:0] head_key;
    logic [TS_W-1:0]   head_ts;
    logic [31:0]       rdata;

`ifdef KEYCODE_EVT_TIMESTAMP_EN
    localparam int ENT_W = DATA_W + TS_W;
    logic [TS_W-1:0]  ts_q;
    logic [ENT_W-1:0] fifo_wdata, fifo_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign fifo_wdata = {ts_q, s2_q};
    assign head_ts    = fifo_rdata[ENT_W-1:DATA_W];
`else
    localparam int ENT_W = DATA_W;
    logic [ENT_W-1:0] fifo_wdata, fifo_rdata;

    assign fifo_wdata = s2_q;
    assign head_ts    = '0;
`endif

    assign head_key  = fifo_rdata[DATA_W-1:0];
    assign rd_strobe = bus.chipselect && !bus.read_n;
    assign wr_strobe = bus.chipselect && !bus.write_n;
    assign pop_req   = rd_strobe && (bus.address == ADDR_DATA);
    assign push_req  = (s2_q != prev_q) && ((CAP_ON_ZERO != 0) || (s2_q != '0));
    // When full, a coincident pop makes room, so only an unpaired push overflows.
    assign ovf_set   = push_req && full && !pop_req;
    assign ovf_clr   = wr_strobe && (bus.address == ADDR_STATUS) && bus.writedata[OVF_BIT];
    assign ovf_d     = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    assign mask_d    = (wr_strobe && (bus.address == ADDR_IRQ_MASK)) ? bus.writedata[0] : mask_q;
    assign irq_d     = mask_d && (count_next != '0);

    keycode_evt_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .push_i       (push_req),
        .pop_i        (pop_req),
        .wdata_i      (fifo_wdata),
        .rdata_o      (fifo_rdata),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            ovf_q  <= 1'b0;
            mask_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            s1_q   <= in_port;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            ovf_q  <= ovf_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA: begin
                if (!empty) begin
                    rdata[31:16]          = head_ts;
                    rdata[VALID_BIT]      = 1'b1;
                    rdata[DATA_W-1:0]     = head_key;
                end
            end
            ADDR_STATUS: begin
                rdata[CNT_LSB +: 8] = 8'(count);
                rdata[OVF_BIT]      = ovf_q;
                rdata[FULL_BIT]     = full;
                rdata[EMPTY_BIT]    = empty;
            end
            ADDR_IRQ_MASK: rdata[0] = mask_q;
            default:       rdata[DATA_W-1:0] = s2_q;
        endcase
    end

    assign bus.readdata = rdata;
    assign irq          = irq_q;

    logic unused_wdata;
    assign unused_wdata = ^{bus.writedata[31:OVF_BIT+1], bus.writedata[OVF_BIT-1:1]};

endmodule

// File: tb/tb_keycode_event_port.sv
// tb/tb_keycode_event_port.sv - self-checking bench for keycode_event_port
module tb_keycode_event_port;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_port = 8'h00;
    logic       irq;

    keycode_event_port_if bus();

    keycode_event_port #(.DATA_W(8), .DEPTH(DEPTH), .CAP_ON_ZERO(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  key;
        logic [15:0] ts;
    } ev_t;

    ev_t         mq[$];
    logic [7:0]  m_hist[3];   // in_port as seen at the last three edges, [0] newest
    logic        m_ovf, m_mask;
    logic [15:0] m_ts;        // edges since reset release
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (mq.size() > 0) begin
`ifdef KEYCODE_EVT_TIMESTAMP_EN
                r[31:16] = mq[0].ts;
`endif
                r[8]   = 1'b1;
                r[7:0] = mq[0].key;
            end
            2'd1: r = {21'b0, mq.size() == 0, mq.size() == DEPTH, m_ovf, 8'(mq.size())};
            2'd2: r = {31'b0, m_mask};
            default: r = {24'b0, m_hist[1]};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hist = '{8'h00, 8'h00, 8'h00};
        m_ovf  = 1'b0;
        m_mask = 1'b0;
        m_ts   = 16'h0;
    endtask

    task automatic model_step(input logic [1:0] a, input bit rd, input bit wr,
                              input logic [31:0] wd, input logic [7:0] k);
        logic [7:0] cur, last;
        bit         setov;
        cur   = m_hist[1];
        last  = m_hist[2];
        setov = 0;
        if (rd && a == 2'd0 && mq.size() > 0) void'(mq.pop_front());
        if (cur != last) begin
            if (mq.size() < DEPTH) mq.push_back('{cur, m_ts});
            else setov = 1;
        end
        if (wr && a == 2'd1 && wd[8]) m_ovf = 1'b0;
        if (setov) m_ovf = 1'b1;
        if (wr && a == 2'd2) m_mask = wd[0];
        m_ts++;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = k;
    endtask

    task automatic cyc(input logic [1:0] a, input bit rd, input bit wr,
                       input logic [31:0] wd, input logic [7:0] k, output logic [31:0] got);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = rd | wr;
        bus.read_n     = !rd;
        bus.write_n    = !wr;
        bus.writedata  = wd;
        in_port        = k;
        #1;
        got = bus.readdata;
        check("readdata", bus.readdata, exp_rd(a));
        check("irq", {31'b0, irq}, {31'b0, m_mask && mq.size() != 0});
        @(posedge clk);
        model_step(a, rd, wr, wd, k);
    endtask

    task automatic do_reset(input logic [7:0] k, input bit check_now);
        @(negedge clk);
        bus.address = 2'd1; bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1;
        bus.writedata = '0;
        in_port = k;
        reset = 1'b1;
        #1;
        if (check_now) begin
            check("rst_status", bus.readdata, 32'h0000_0400);
            check("rst_irq", {31'b0, irq}, 32'h0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_step(2'd1, 0, 0, 32'h0, k);
    endtask

    task automatic idle(input int n, input logic [7:0] k);
        for (int i = 0; i < n; i++) cyc(2'd1, 0, 0, 32'h0, k, seen);
    endtask

    initial begin
        bus.address = 2'd0; bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1;
        bus.writedata = '0;
        model_reset();

        do_reset(8'h00, 1);
        cyc(2'd0, 0, 0, 0, 8'h00, seen);   check("reset_data", seen, 32'h0);
        cyc(2'd1, 1, 0, 0, 8'h00, seen);   check("reset_status", seen, 32'h400);

        // single event
        idle(3, 8'h1A);
        cyc(2'd1, 1, 0, 0, 8'h1A, seen);   check("one_status", seen, 32'h001);
        cyc(2'd0, 1, 0, 0, 8'h1A, seen);   check("one_data", seen & 32'hFFFF, 32'h11A);
        cyc(2'd1, 1, 0, 0, 8'h1A, seen);   check("one_empty", seen, 32'h400);

        // interrupt on press and release
        cyc(2'd2, 0, 1, 32'h1, 8'h1A, seen);
        idle(4, 8'h04);
        idle(4, 8'h00);
        #1 check("irq_high", {31'b0, irq}, 32'h1);
        cyc(2'd0, 1, 0, 0, 8'h00, seen);   check("rel_data0", seen & 32'hFFFF, 32'h104);
        cyc(2'd0, 1, 0, 0, 8'h00, seen);   check("rel_data1", seen & 32'hFFFF, 32'h100);
        #1 check("irq_low", {31'b0, irq}, 32'h0);

        // overflow
        for (int v = 1; v <= 5; v++) idle(2, 8'(v * 'h11));
        idle(3, 8'h55);
        cyc(2'd1, 1, 0, 0, 8'h55, seen);   check("ovf_status", seen, 32'h304);
        for (int v = 1; v <= 4; v++) begin
            cyc(2'd0, 1, 0, 0, 8'h55, seen);
            check("ovf_drain", seen & 32'hFFFF, 32'h100 | 32'(v * 'h11));
        end
        cyc(2'd1, 0, 1, 32'h100, 8'h55, seen);
        cyc(2'd1, 1, 0, 0, 8'h55, seen);   check("ovf_clear", seen, 32'h400);

        // full with coincident push and pop
        for (int v = 1; v <= 4; v++) idle(2, 8'(8'h60 + v));
        idle(3, 8'h64);
        idle(2, 8'h65);
        cyc(2'd0, 1, 0, 0, 8'h65, seen);   check("full_pp_data", seen & 32'hFFFF, 32'h161);
        cyc(2'd1, 1, 0, 0, 8'h65, seen);   check("full_pp_status", seen, 32'h204);
        for (int v = 2; v <= 5; v++) begin
            cyc(2'd0, 1, 0, 0, 8'h65, seen);
            check("full_pp_drain", seen & 32'hFFFF, 32'h160 | 32'(v));
        end

        // empty read and live view
        cyc(2'd0, 1, 0, 0, 8'h65, seen);   check("empty_read", seen, 32'h0);
        cyc(2'd1, 1, 0, 0, 8'h65, seen);   check("empty_status", seen, 32'h400);
        idle(3, 8'h3C);
        cyc(2'd3, 1, 0, 0, 8'h3C, seen);   check("live", seen, 32'h3C);
        cyc(2'd1, 1, 0, 0, 8'h3C, seen);   check("live_status", seen, 32'h001);

        // randomized traffic: low then high read pressure
        for (int ph = 0; ph < 2; ph++) begin
            logic [7:0] k;
            k = in_port;
            for (int i = 0; i < 300; i++) begin
                int op;
                logic [1:0] a;
                if ($urandom_range(0, 3) == 0)
                    k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                op = $urandom_range(0, 15);
                a  = 2'($urandom);
                if (op < (ph == 0 ? 2 : 7))
                    cyc(($urandom_range(0, 2) == 0) ? a : 2'd0, 1, 0, 0, k, seen);
                else if (op == 8)
                    cyc(2'd1, 0, 1, $urandom, k, seen);
                else if (op == 9)
                    cyc(2'd2, 0, 1, $urandom, k, seen);
                else if (op == 10)
                    cyc(a, 0, 1, $urandom, k, seen);
                else
                    cyc(a, 0, 0, 0, k, seen);
            end
        end

        // reset in the middle of a drain
        cyc(2'd1, 0, 1, 32'h100, in_port, seen);
        for (int v = 1; v <= 4; v++) idle(2, 8'(8'h70 + v));
        idle(3, 8'h74);
        cyc(2'd2, 0, 1, 32'h1, 8'h74, seen);
        cyc(2'd0, 1, 0, 0, 8'h74, seen);
        cyc(2'd1, 1, 0, 0, 8'h74, seen);   check("pre_rst_status", seen & 32'h1FF, 32'h003);
        do_reset(8'h77, 1);
        idle(3, 8'h77);
        cyc(2'd0, 1, 0, 0, 8'h77, seen);   check("post_rst_data", seen & 32'hFFFF, 32'h177);
`ifdef KEYCODE_EVT_TIMESTAMP_EN
        check("post_rst_ts", {16'h0, seen[31:16]}, 32'h2);
`else
        check("post_rst_ts", {16'h0, seen[31:16]}, 32'h0);
`endif
        idle(2, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
